// File: rtl/execute_unit.sv
// Execute stage of the multicycle MIPS core: single-cycle ALU ops plus
// iterative MULTU/DIVU into internal HI/LO, all results registered.
module execute_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [3:0]               alu_op,
  input  logic [WIDTH-1:0]         operand_a,
  input  logic [WIDTH-1:0]         operand_b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     overflow,
  output logic                     busy,
  output logic                     exec_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MULT = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_MFHI = 4'd14;
  localparam logic [3:0] OP_MFLO = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hi, r_lo;
  // Working registers: r_wh/r_wl hold partial product or remainder/quotient.
  logic [WIDTH-1:0] r_wh, r_wl, r_opb;

  logic [WIDTH-1:0] w_sum, w_diff, w_alu;
  logic             w_ovf;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_hi, w_div_lo;

  // Single-cycle ALU
  always_comb begin
    w_sum  = operand_a + operand_b;
    w_diff = operand_a - operand_b;
    w_alu  = '0;
    w_ovf  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_alu = w_sum;
        w_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu = w_diff;
        w_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  w_alu = operand_a & operand_b;
      OP_OR:   w_alu = operand_a | operand_b;
      OP_XOR:  w_alu = operand_a ^ operand_b;
      OP_NOR:  w_alu = ~(operand_a | operand_b);
      OP_SLT:  w_alu = WIDTH'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: w_alu = WIDTH'(operand_a < operand_b);
      OP_SLL:  w_alu = operand_b << shamt;
      OP_SRL:  w_alu = operand_b >> shamt;
      OP_SRA:  w_alu = WIDTH'($signed(operand_b) >>> shamt);
      OP_LUI:  w_alu = {operand_b[WIDTH/2-1:0], (WIDTH/2)'(0)};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // One shift-add step: conditionally add multiplicand to the high half, shift right.
  always_comb begin
    w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opb} : (WIDTH+1)'(0));
    w_mul_hi  = w_mul_sum[WIDTH:1];
    w_mul_lo  = {w_mul_sum[0], r_wl[WIDTH-1:1]};
  end

  // One restoring-divide step; a zero divisor always "fits", giving all-ones quotient.
  always_comb begin
    w_rem_sh = {r_wh, r_wl[WIDTH-1]};
    w_div_ge = (w_rem_sh >= {1'b0, r_opb});
    w_div_hi = w_div_ge ? WIDTH'(w_rem_sh - {1'b0, r_opb}) : w_rem_sh[WIDTH-1:0];
    w_div_lo = {r_wl[WIDTH-2:0], w_div_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_wh      <= '0;
      r_wl      <= '0;
      r_opb     <= '0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      exec_done <= 1'b0;
    end else begin
      exec_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            if (alu_op == OP_MULT || alu_op == OP_DIV) begin
              r_wh    <= '0;
              r_wl    <= operand_a;
              r_opb   <= operand_b;
              r_count <= '0;
              busy    <= 1'b1;
              r_state <= (alu_op == OP_MULT) ? S_MUL : S_DIV;
            end else begin
              result    <= w_alu;
              zero      <= (w_alu == '0);
              overflow  <= w_ovf;
              exec_done <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_wh    <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
          r_wl    <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_ITER) begin
            r_hi      <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
            r_lo      <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
            result    <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
            zero      <= (((r_state == S_MUL) ? w_mul_lo : w_div_lo) == '0);
            overflow  <= 1'b0;
            busy      <= 1'b0;
            exec_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: table of single-cycle vectors plus
// hand-written MULTU/DIVU, en-while-busy and mid-sequence reset sequences.
module tb_execute_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  alu_op;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero, overflow, busy, exec_done;

  int n_vec = 0;
  int n_err = 0;

  execute_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .shamt(shamt),
    .result(result), .zero(zero), .overflow(overflow),
    .busy(busy), .exec_done(exec_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] exp_r;
    logic        exp_z, exp_o;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Result/zero/overflow/busy/exec_done packed into one word for comparison.
  function automatic logic [63:0] pack_out(logic [31:0] r, logic z, logic o, logic b, logic d);
    return {28'h0, z, o, b, d, r};
  endfunction

  // Issue a single-cycle op at the next edge; leaves en high for back-to-back use.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] er, input logic ez, input logic eo);
    @(negedge clk);
    en = 1'b1; alu_op = op; operand_a = a; operand_b = b; shamt = sh;
    @(posedge clk); #1;
    chk(name, pack_out(result, zero, overflow, busy, exec_done),
        pack_out(er, ez, eo, 1'b0, 1'b1));
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk(name, {63'h0, exec_done}, 64'h0);
  endtask

  // MULTU/DIVU: busy from E, exec_done only at E+32; optional en pulse sampled at E+5.
  task automatic do_mc(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_lo, input bit pulse);
    @(negedge clk);
    en = 1'b1; alu_op = op; operand_a = a; operand_b = b; shamt = '0;
    @(posedge clk); #1;
    chk({name, "_start"}, {62'h0, busy, exec_done}, 64'h2);
    en = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (pulse && k == 5) begin
        en = 1'b1; alu_op = 4'd0; operand_a = 32'h1; operand_b = 32'h1;
      end
      @(posedge clk); #1;
      en = 1'b0;
      if (k < 32)
        chk({name, "_busy"}, {62'h0, busy, exec_done}, 64'h2);
    end
    chk({name, "_done"}, pack_out(result, zero, overflow, busy, exec_done),
        pack_out(exp_lo, exp_lo == 32'h0, 1'b0, 1'b0, 1'b1));
    @(posedge clk); #1;
    chk({name, "_pulse1"}, {63'h0, exec_done}, 64'h0);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{"mfhi_rst", 4'd14, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{"mflo_rst", 4'd15, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{"add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 1'b0, 1'b1});
    tbl.push_back('{"sub_zero", 4'd1, 32'h5, 32'h5, 5'd0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{"slt", 4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0});
    tbl.push_back('{"sltu", 4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{"sra", 4'd10, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0});
    tbl.push_back('{"srl", 4'd9, 32'h0, 32'h80000000, 5'd4, 32'h08000000, 1'b0, 1'b0});
    tbl.push_back('{"lui", 4'd11, 32'h0, 32'h1234, 5'd0, 32'h12340000, 1'b0, 1'b0});
    tbl.push_back('{"and", 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0});
    tbl.push_back('{"or", 4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 1'b0, 1'b0});
    tbl.push_back('{"xor", 4'd4, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 1'b0, 1'b0});
    tbl.push_back('{"nor", 4'd5, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{"sll31", 4'd8, 32'h0, 32'h1, 5'd31, 32'h80000000, 1'b0, 1'b0});
    tbl.push_back('{"sub_ovf", 4'd1, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1});
    tbl.push_back('{"add_wrap", 4'd0, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0});
    tbl.push_back('{"slt_pos", 4'd6, 32'h1, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 1'b0});

    rst_n = 1'b0; en = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset", pack_out(result, zero, overflow, busy, exec_done),
           pack_out(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i])
      do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
            tbl[i].exp_r, tbl[i].exp_z, tbl[i].exp_o);
    idle_check("idle_no_done");
    @(posedge clk); #1;
    chk("idle_hold", pack_out(result, zero, overflow, busy, exec_done),
        pack_out(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));

    do_mc("multu_max", 4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    do_op("mfhi_mul", 4'd14, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op("mflo_mul", 4'd15, 32'h0, 32'h0, 5'd0, 32'h00000001, 1'b0, 1'b0);
    idle_check("idle2");

    do_mc("divu_100_7", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0);
    do_op("mfhi_div", 4'd14, 32'h0, 32'h0, 5'd0, 32'd2, 1'b0, 1'b0);
    idle_check("idle3");

    do_mc("divu_by0", 4'd13, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0);
    do_op("mfhi_div0", 4'd14, 32'h0, 32'h0, 5'd0, 32'd9, 1'b0, 1'b0);
    do_op("mflo_div0", 4'd15, 32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    idle_check("idle4");

    do_mc("multu_small", 4'd12, 32'd6, 32'd7, 32'd42, 1'b0);
    do_op("mfhi_small", 4'd14, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle_check("idle5");

    // Reset in the middle of a MULTU, then MFLO must see the cleared LO.
    @(negedge clk);
    en = 1'b1; alu_op = 4'd12; operand_a = 32'h12345678; operand_b = 32'h9ABCDEF0;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", pack_out(result, zero, overflow, busy, exec_done),
           pack_out(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;
    do_op("mflo_after_rst", 4'd15, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle_check("idle6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
